// File: rtl/ov7670_dvp_source.sv
// OV7670 DVP bus source: stands in for the camera sensor and emits pclk,
// vsync, href and RGB565 bytes with OV7670-style VGA timing. The patterns
// are ramp, colour bars, solid colour and line ramp.
// All bus outputs move only on "ticks". A tick is the clk27 edge on which
// pclk_out falls, so the bus is stable at every rising edge of pclk_out.
module ov7670_dvp_source #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 784,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 510
) (
    input  logic        clk27,
    input  logic        clr,
    input  logic        run,
    input  logic [1:0]  mode,
    input  logic [15:0] fixed_rgb,
    output logic        pclk_out,
    output logic        vsync_out,
    output logic        href_out,
    output logic [7:0]  d_out,
    output logic        frame_start,
    output logic        busy,
    output logic [7:0]  frame_count
);

    localparam int H_BYTES   = 2 * H_TOTAL;
    // Counters are at least 8 bits wide so that the ramp patterns can
    // take their low byte directly.
    localparam int HW        = ($clog2(H_BYTES) > 8) ? $clog2(H_BYTES) : 8;
    localparam int VW        = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
    // Each of the eight bars is H_ACTIVE/8 pixels wide, so H_ACTIVE/4 bytes.
    localparam int BAR_BYTES = H_ACTIVE / 4;
    localparam int BW        = (BAR_BYTES > 1) ? $clog2(BAR_BYTES) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_BYTES - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(2 * H_ACTIVE);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_FIRST    = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_BYTES - 1);

    typedef enum logic {
        S_IDLE,
        S_FRAME
    } state_t;

    state_t          state_q, state_d;
    logic            pclk_q, pclk_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [BW-1:0]   bar_byte_q, bar_byte_d;
    logic [2:0]      bar_idx_q, bar_idx_d;
    logic [1:0]      mode_q, mode_d;
    logic [15:0]     rgb_q, rgb_d;
    logic [7:0]      count_q, count_d;
    logic            start_q, start_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      data_q, data_d;
    logic            busy_q, busy_d;

    logic            tick;
    logic            begin_frame;
    logic            go_idle;
    logic            advance;
    logic            line_on;
    logic [7:0]      line_byte;
    logic [15:0]     pix_word;
    logic [7:0]      pix_byte;

    // The pclk flop is high just before the edge on which it falls, so that
    // edge is a tick.
    assign tick = pclk_q;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 16'hFFFF;
            3'd1:    bar_colour = 16'hFFE0;
            3'd2:    bar_colour = 16'h07FF;
            3'd3:    bar_colour = 16'h07E0;
            3'd4:    bar_colour = 16'hF81F;
            3'd5:    bar_colour = 16'hF800;
            3'd6:    bar_colour = 16'h001F;
            default: bar_colour = 16'h0000;
        endcase
    endfunction

    // Next-state logic: FSM transitions, raster counters, bar tracking and
    // the registered bus values for the byte position being entered.
    always_comb begin
        // NOTE: every variable gets a hold/default value first, so no
        // path through this block can leave one unassigned and infer a latch.
        state_d     = state_q;
        pclk_d      = ~pclk_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        bar_byte_d  = bar_byte_q;
        bar_idx_d   = bar_idx_q;
        mode_d      = mode_q;
        rgb_d       = rgb_q;
        count_d     = count_q;
        start_d     = 1'b0;
        vsync_d     = vsync_q;
        href_d      = href_q;
        data_d      = data_q;
        busy_d      = busy_q;
        begin_frame = 1'b0;
        go_idle     = 1'b0;
        advance     = 1'b0;
        line_on     = 1'b0;
        line_byte   = 8'h00;
        pix_word    = 16'h0000;
        pix_byte    = 8'h00;

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        begin_frame = 1'b1;
                    end
                end
                S_FRAME: begin
                    if (h_cnt_q == H_LAST && v_cnt_q == V_LAST) begin
                        // A frame is never cut short. run is only looked
                        // at on the last byte of the frame.
                        if (run) begin
                            begin_frame = 1'b1;
                        end else begin
                            go_idle = 1'b1;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: go_idle = 1'b1;
            endcase
        end

        if (begin_frame) begin
            state_d = S_FRAME;
            h_cnt_d = '0;
            v_cnt_d = '0;
            mode_d  = mode;
            rgb_d   = fixed_rgb;
            count_d = count_q + 8'd1;
            start_d = 1'b1;
        end else if (go_idle) begin
            state_d = S_IDLE;
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (advance) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end

        // The bar index is found by counting bytes within the current bar,
        // which avoids a divider. The count restarts at the start of each line.
        if (h_cnt_d == '0) begin
            bar_byte_d = '0;
            bar_idx_d  = 3'd0;
        end else if (advance) begin
            if (bar_byte_q == BAR_LAST) begin
                bar_byte_d = '0;
                bar_idx_d  = bar_idx_q + 3'd1;
            end else begin
                bar_byte_d = bar_byte_q + 1'b1;
            end
        end

        line_on   = (v_cnt_d >= V_FIRST) && (v_cnt_d < V_ACT_END);
        line_byte = v_cnt_d[7:0] - V_FIRST[7:0];

        case (mode_d)
            2'd1:    pix_word = bar_colour(bar_idx_d);
            2'd2:    pix_word = rgb_d;
            default: pix_word = 16'h0000;
        endcase

        case (mode_d)
            2'd0:    pix_byte = h_cnt_d[7:0];
            2'd3:    pix_byte = line_byte;
            default: pix_byte = h_cnt_d[0] ? pix_word[7:0] : pix_word[15:8];
        endcase

        if (begin_frame || advance) begin
            busy_d  = 1'b1;
            vsync_d = (v_cnt_d < V_SYNC_END);
            href_d  = line_on && (h_cnt_d < H_ACT_END);
            data_d  = href_d ? pix_byte : 8'h00;
        end else if (go_idle) begin
            busy_d  = 1'b0;
            vsync_d = 1'b0;
            href_d  = 1'b0;
            data_d  = 8'h00;
        end
    end

    // State register. clr clears every flop immediately, without waiting
    // for a clock edge.
    always_ff @(posedge clk27 or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            pclk_q     <= 1'b0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            bar_byte_q <= '0;
            bar_idx_q  <= 3'd0;
            mode_q     <= 2'd0;
            rgb_q      <= 16'h0000;
            count_q    <= 8'h00;
            start_q    <= 1'b0;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            data_q     <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from
            // pre-edge values, so the order of these lines does not matter.
            state_q    <= state_d;
            pclk_q     <= pclk_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            bar_byte_q <= bar_byte_d;
            bar_idx_q  <= bar_idx_d;
            mode_q     <= mode_d;
            rgb_q      <= rgb_d;
            count_q    <= count_d;
            start_q    <= start_d;
            vsync_q    <= vsync_d;
            href_q     <= href_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
        end
    end

    assign pclk_out    = pclk_q;
    assign vsync_out   = vsync_q;
    assign href_out    = href_q;
    assign d_out       = data_q;
    assign frame_start = start_q;
    assign busy        = busy_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_ov7670_dvp_source.sv
// Self-checking bench for ov7670_dvp_source using reduced frame timing.
// The reference model tracks a linear byte position within the frame and
// derives line, column, bar and pixel values from it arithmetically.
module tb_ov7670_dvp_source;

    localparam int HA      = 8;
    localparam int HT      = 10;
    localparam int VS      = 1;
    localparam int VB      = 1;
    localparam int VA      = 2;
    localparam int VT      = 5;
    localparam int LINE_B  = 2 * HT;
    localparam int FRAME_B = LINE_B * VT;

    logic        clk27 = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] fixed_rgb = 16'h0000;
    logic        pclk_out;
    logic        vsync_out;
    logic        href_out;
    logic [7:0]  d_out;
    logic        frame_start;
    logic        busy;
    logic [7:0]  frame_count;

    always #5 clk27 = ~clk27;

    ov7670_dvp_source #(
        .H_ACTIVE (HA),
        .H_TOTAL  (HT),
        .V_SYNC   (VS),
        .V_BACK   (VB),
        .V_ACTIVE (VA),
        .V_TOTAL  (VT)
    ) dut (
        .clk27       (clk27),
        .clr         (clr),
        .run         (run),
        .mode        (mode),
        .fixed_rgb   (fixed_rgb),
        .pclk_out    (pclk_out),
        .vsync_out   (vsync_out),
        .href_out    (href_out),
        .d_out       (d_out),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_count (frame_count)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    // Reference model state.
    int          m_edges;
    bit          m_active;
    int          m_pos;
    logic [1:0]  m_mode;
    logic [15:0] m_rgb;
    int          m_count;
    bit          m_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edges  = 0;
        m_active = 0;
        m_pos    = 0;
        m_mode   = 2'd0;
        m_rgb    = 16'h0000;
        m_count  = 0;
        m_start  = 0;
    endtask

    task automatic check_outputs();
        int          h;
        int          v;
        int          a;
        bit          on;
        logic [15:0] px;
        logic [7:0]  b;
        h  = m_pos % LINE_B;
        v  = m_pos / LINE_B;
        a  = v - (VS + VB);
        on = m_active && (a >= 0) && (a < VA) && (h < 2 * HA);
        px = 16'h0000;
        case (m_mode)
            2'd0:    b = h[7:0];
            2'd1:    begin px = bars[(h / 2) / (HA / 8)]; b = (h % 2 == 0) ? px[15:8] : px[7:0]; end
            2'd2:    begin px = m_rgb; b = (h % 2 == 0) ? px[15:8] : px[7:0]; end
            default: b = a[7:0];
        endcase
        if (!on) b = 8'h00;
        check("pclk",        32'(pclk_out),    32'((m_edges % 2) == 1));
        check("vsync",       32'(vsync_out),   32'(m_active && v < VS));
        check("href",        32'(href_out),    32'(on));
        check("d_out",       32'(d_out),       32'(b));
        check("busy",        32'(busy),        32'(m_active));
        check("frame_start", 32'(frame_start), 32'(m_start));
        check("frame_count", 32'(frame_count), 32'(m_count));
    endtask

    // One clk27 cycle: update the model at the rising edge, then compare
    // the DUT outputs 1 time unit later.
    task automatic step();
        @(posedge clk27);
        if (!clr) begin
            model_reset();
        end else begin
            m_edges++;
            m_start = 0;
            if (m_edges % 2 == 0) begin
                if (!m_active || m_pos == FRAME_B - 1) begin
                    if (run) begin
                        m_active = 1;
                        m_pos    = 0;
                        m_mode   = mode;
                        m_rgb    = fixed_rgb;
                        m_count  = (m_count + 1) % 256;
                        m_start  = 1;
                    end else begin
                        m_active = 0;
                        m_pos    = 0;
                    end
                end else begin
                    m_pos++;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert clr between clock edges and confirm that the outputs clear
    // without waiting for an edge.
    task automatic async_reset();
        clr = 1'b0;
        #1;
        model_reset();
        check_outputs();
        steps(3);
        clr = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_outputs();
        steps(3);
        clr = 1'b1;

        // Ramp pattern. run is dropped mid-frame, but the frame still completes.
        mode = 2'd0; run = 1'b1;
        steps(20);
        run = 1'b0;
        steps(260);

        // Colour bars.
        mode = 2'd1; run = 1'b1;
        steps(10);
        run = 1'b0;
        steps(220);

        // Solid colour. fixed_rgb and mode changes mid-frame wait for the next frame.
        mode = 2'd2; fixed_rgb = 16'h1234; run = 1'b1;
        steps(100);
        fixed_rgb = 16'hABCD; mode = 2'd3;
        steps(150);
        mode = 2'd2;
        run = 1'b0;
        steps(250);

        // Line ramp.
        mode = 2'd3; run = 1'b1;
        steps(30);
        run = 1'b0;
        steps(220);

        // Randomised run, mode and colour, changed at random points.
        for (int i = 0; i < 30; i++) begin
            run       = ($urandom_range(0, 3) != 0);
            mode      = 2'($urandom_range(0, 3));
            fixed_rgb = 16'($urandom);
            steps($urandom_range(1, 150));
        end
        run = 1'b0;
        steps(420);

        // Reset asserted mid-frame, then a fresh frame after release.
        run = 1'b1; mode = 2'd0;
        steps(77);
        async_reset();
        steps(250);
        run = 1'b0;
        steps(250);

        // Continuous frames through the frame_count wrap from 255 to 0.
        async_reset();
        run = 1'b1; mode = 2'($urandom_range(0, 3)); fixed_rgb = 16'($urandom);
        steps(256 * 2 * FRAME_B + 10);
        run = 1'b0;
        steps(2 * FRAME_B + 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
